// File: rtl/lcd1602_row_writer.sv
// lcd1602_row_writer: powers up a 1602 HD44780 panel in 4-bit mode, then refreshes two 16-char rows forever
module lcd1602_row_writer #(
    parameter int T_PWR  = 2_000_000,
    parameter int T_INIT = 410_000,
    parameter int T_SU   = 4,
    parameter int T_EH   = 25,
    parameter int T_HOLD = 100,
    parameter int T_CMD  = 4_000,
    parameter int T_CLR  = 164_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] row_A,
    input  logic [127:0] row_B,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_E,
    output logic [3:0]   LCD_D,
    output logic         init_done,
    output logic         frame_done
);
    localparam int M1 = T_PWR > T_INIT ? T_PWR : T_INIT;
    localparam int M2 = M1 > T_CLR ? M1 : T_CLR;
    localparam int M3 = M2 > T_CMD ? M2 : T_CMD;
    localparam int M4 = M3 > T_HOLD ? M3 : T_HOLD;
    localparam int M5 = M4 > T_EH ? M4 : T_EH;
    localparam int TM = M5 > T_SU ? M5 : T_SU;
    localparam int TW = $clog2(TM + 1);

    typedef enum logic [1:0] {PWR, INIT, LINE1, LINE2} state_t;
    typedef enum logic [1:0] {SU, EH, HOLD, WAIT} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [TW-1:0]  timer_q, timer_d, wait_t;
    logic [4:0]     idx_q, idx_d;
    logic           lo_q, lo_d, rs_q, rs_d, e_q, e_d;
    logic [3:0]     d_q, d_d;
    logic           init_done_q, init_done_d, frame_done_q, frame_done_d;
    logic [255:0]   snap_q, snap_d;
    logic [7:0]     cur_byte, nxt_byte;
    logic           single, last;

    // Byte sent at step idx of a state: init nibbles sit in the high half, line step 0 is the DDRAM address
    function automatic logic [7:0] byte_at(input state_t st, input logic [4:0] idx, input logic [255:0] sn);
        logic [3:0] p = idx[3:0] - 4'd1;
        case (st)
            INIT:    return idx[2] ? (idx[1] ? (idx[0] ? 8'h01 : 8'h06) : (idx[0] ? 8'h0C : 8'h28))
                                   : (idx[1:0] == 2'd3 ? 8'h20 : 8'h30);
            LINE1,
            LINE2:   return idx == 5'd0 ? (st == LINE1 ? 8'h80 : 8'hC0) : sn[{st == LINE1, ~p, 3'b000} +: 8];
            default: return 8'h00;
        endcase
    endfunction

    // Nibble sequencer: SU -> EH -> HOLD per nibble, WAIT after each byte or single init nibble
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        lo_d         = lo_q;
        rs_d         = rs_q;
        e_d          = e_q;
        d_d          = d_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        snap_d       = snap_q;
        nxt_byte     = 8'h00;
        cur_byte     = byte_at(state_q, idx_q, snap_q);
        single       = state_q == INIT && idx_q < 5'd4;
        last         = idx_q == (state_q == INIT ? 5'd7 : 5'd16);
        wait_t       = single ? (idx_q == 5'd0 ? TW'(T_INIT - 1) : TW'(T_CMD - 1))
                              : (!rs_q && cur_byte == 8'h01) ? TW'(T_CLR - 1) : TW'(T_CMD - 1);
        if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end else if (state_q == PWR) begin
            state_d = INIT;
            idx_d   = '0;
            lo_d    = 1'b0;
            phase_d = SU;
            timer_d = TW'(T_SU - 1);
            rs_d    = 1'b0;
            d_d     = 4'h3;
        end else begin
            case (phase_q)
                SU: begin
                    phase_d = EH;
                    e_d     = 1'b1;
                    timer_d = TW'(T_EH - 1);
                end
                EH: begin
                    phase_d = HOLD;
                    e_d     = 1'b0;
                    timer_d = TW'(T_HOLD - 1);
                end
                HOLD: begin
                    phase_d = (single || lo_q) ? WAIT : SU;
                    timer_d = (single || lo_q) ? wait_t : TW'(T_SU - 1);
                    lo_d    = !(single || lo_q) || lo_q;
                    d_d     = (single || lo_q) ? d_q : cur_byte[3:0];
                end
                default: begin
                    lo_d    = 1'b0;
                    phase_d = SU;
                    timer_d = TW'(T_SU - 1);
                    idx_d   = last ? 5'd0 : idx_q + 5'd1;
                    if (last) begin
                        state_d      = state_q == LINE1 ? LINE2 : LINE1;
                        snap_d       = state_q == LINE1 ? snap_q : {row_A, row_B};
                        init_done_d  = 1'b1;
                        frame_done_d = state_q == LINE2;
                    end
                    nxt_byte = byte_at(state_d, idx_d, snap_d);
                    rs_d     = state_d != INIT && idx_d != 5'd0;
                    d_d      = nxt_byte[7:4];
                end
            endcase
        end
    end

    // State registers; reset drops E at once and restarts from the power-up wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PWR;
            phase_q      <= SU;
            timer_q      <= TW'(T_PWR - 1);
            idx_q        <= '0;
            lo_q         <= 1'b0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            d_q          <= 4'h0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            lo_q         <= lo_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            d_q          <= d_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            snap_q       <= snap_d;
        end
    end

    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_E      = e_q;
    assign LCD_D      = d_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd1602_row_writer.sv
// tb_lcd1602_row_writer: scoreboard bench for the 1602 row writer with a nibble-stream reference model
module tb_lcd1602_row_writer;
    localparam int T_PWR = 50, T_INIT = 20, T_SU = 2, T_EH = 3, T_HOLD = 4, T_CMD = 10, T_CLR = 30;
    localparam int BUDGET = 5000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] row_A, row_B;
    logic         LCD_RS, LCD_RW, LCD_E, init_done, frame_done;
    logic [3:0]   LCD_D;

    lcd1602_row_writer #(
        .T_PWR(T_PWR), .T_INIT(T_INIT), .T_SU(T_SU), .T_EH(T_EH),
        .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .clk(clk), .reset(reset), .row_A(row_A), .row_B(row_B),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_D(LCD_D),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         gap;
    } nib_t;

    nib_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, nibs = 0, frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the expected nibble stream and the fall-to-next-rise gap after each nibble
    task automatic push_nib(input logic rs, input logic [3:0] d, input int w);
        nib_t n;
        n.rs  = rs;
        n.d   = d;
        n.gap = T_HOLD + w + T_SU;
        exp_q.push_back(n);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b, input int w);
        push_nib(rs, b[7:4], 0);
        push_nib(rs, b[3:0], w);
    endtask

    task automatic push_init();
        push_nib(1'b0, 4'h3, T_INIT);
        push_nib(1'b0, 4'h3, T_CMD);
        push_nib(1'b0, 4'h3, T_CMD);
        push_nib(1'b0, 4'h2, T_CMD);
        push_byte(1'b0, 8'h28, T_CMD);
        push_byte(1'b0, 8'h0C, T_CMD);
        push_byte(1'b0, 8'h06, T_CMD);
        push_byte(1'b0, 8'h01, T_CLR);
    endtask

    task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
        push_byte(1'b0, 8'h80, T_CMD);
        for (int i = 0; i < 16; i++) push_byte(1'b1, a[127-8*i -: 8], T_CMD);
        push_byte(1'b0, 8'hC0, T_CMD);
        for (int i = 0; i < 16; i++) push_byte(1'b1, b[127-8*i -: 8], T_CMD);
    endtask

    // Monitor: protocol timing, scoreboard pop on each E fall, init_done/frame_done placement
    logic       prev_e = 1'b0, prev_fd = 1'b0;
    logic [4:0] prev_rsd = 5'h0;
    int         stable = 0, ehw = 0, fall_cyc = 0, exp_gap = -1;
    nib_t       got_e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_e   = 1'b0;
            prev_fd  = 1'b0;
            stable   = 0;
            ehw      = 0;
            exp_gap  = -1;
            nibs     = 0;
            prev_rsd = {LCD_RS, LCD_D};
        end else begin
            stable = ({LCD_RS, LCD_D} != prev_rsd) ? 0 : stable + 1;
            if (LCD_E && !prev_e) begin
                chk("rw_low", LCD_RW, 1'b0);
                chk("setup_stable", stable >= T_SU, 1'b1);
                if (exp_gap >= 0) chk("gap_to_rise", cyc - fall_cyc, exp_gap);
                if (nibs >= 12) chk("init_done_high", init_done, 1'b1);
                ehw = 0;
            end
            if (LCD_E) ehw++;
            if (!LCD_E && prev_e) begin
                nibs++;
                fall_cyc = cyc;
                chk("e_width", ehw, T_EH);
                chk("rsd_held_to_fall", stable >= T_SU + T_EH, 1'b1);
                if (nibs == 12) chk("init_done_low_at_last_init", init_done, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_nibble: got rs=%0b d=%0h required none", LCD_RS, LCD_D);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("nibble", {LCD_RS, LCD_D}, {got_e.rs, got_e.d});
                    exp_gap = got_e.gap;
                end
            end
            if (frame_done) begin
                chk("frame_done_width", prev_fd, 1'b0);
                chk("frame_done_pos", (nibs - 12) % 68, 0);
                frames++;
            end
            prev_e   = LCD_E;
            prev_fd  = frame_done;
            prev_rsd = {LCD_RS, LCD_D};
        end
    end

    task automatic wait_nibs(input int target);
        int n = 0;
        while (nibs < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (nibs < target) begin
            checks++;
            errors++;
            $display("FAIL timeout_nibs: got %0d required %0d", nibs, target);
        end
    endtask

    task automatic release_and_check_pwr();
        int rises = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (T_PWR) begin
            @(negedge clk);
            if (LCD_E) rises++;
        end
        chk("pwr_quiet", rises, 0);
    endtask

    // Stimulus: reset, fixed text, mid-frame row change, random rows, reset mid-transfer
    initial begin
        int base, n;
        row_A = "Press BTN2 TO   ";
        row_B = "start calcualte ";
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_E", LCD_E, 1'b0);
        chk("rst_RS", LCD_RS, 1'b0);
        chk("rst_RW", LCD_RW, 1'b0);
        chk("rst_D", LCD_D, 4'h0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        push_init();
        push_frame(row_A, row_B);
        release_and_check_pwr();
        wait_nibs(12 + 20);
        push_frame(row_A, row_B);
        wait_nibs(12 + 68 + 2 + 10 + 1);
        row_A = {16{8'h58}};
        push_frame(row_A, row_B);
        for (int k = 3; k <= 6; k++) begin
            wait_nibs(12 + (k - 1) * 68 + int'($urandom_range(1, 68)));
            row_A = {$urandom, $urandom, $urandom, $urandom};
            row_B = {$urandom, $urandom, $urandom, $urandom};
            push_frame(row_A, row_B);
        end
        wait_nibs(12 + 6 * 68 + 34 + 2 + 14 + 1);
        n = 0;
        while (!LCD_E && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("e_high_before_reset", LCD_E, 1'b1);
        chk("frames_before_reset", frames, 6);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_E", LCD_E, 1'b0);
        chk("rst_async_init_done", init_done, 1'b0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        push_init();
        push_frame(row_A, row_B);
        base = frames;
        release_and_check_pwr();
        wait_nibs(12 + 68);
        n = 0;
        while (frames < base + 1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("frames_after_restart", frames, base + 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("init_done_final", init_done, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
